caeco_sample_feeder: RTL

Memory-mapped front end that accepts ECG samples and commands from the core's store path and streams them to the CAECO accelerator. Sits between the peripheral address decode (data word 0xC0000010, command word 0xC0000011) and the CAECO sample input. It buffers samples in a FIFO, stalls the bus when full, and marks the final sample of a record. The same port serves both core stores and JTAG-initiated memory writes.

---
 rtl/caeco_sample_feeder_pkg.sv | 40 ++++
 rtl/caeco_sample_feeder_if.sv | 24 ++
 rtl/caeco_sample_fifo.sv | 50 +++++
 rtl/caeco_sample_feeder.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/caeco_sample_feeder_pkg.sv
// rtl/caeco_sample_feeder_pkg.sv - shared CMD/STATUS layout, register offsets and FSM states
package caeco_sample_feeder_pkg;

    localparam int CMD_EN_BIT      = 4;
    localparam int CMD_EOR_BIT     = 3;
    localparam int CMD_IRQ_CLR_BIT = 2;
    localparam int CMD_START_BIT   = 0;

    localparam int ST_EOR_BIT   = 3;
    localparam int ST_EN_BIT    = 4;
    localparam int ST_STATE_LSB = 5;
    localparam int ST_OVF_BIT   = 7;
    localparam int ST_LEVEL_LSB = 16;

    localparam logic REG_DATA = 1'b0;
    localparam logic REG_CMD  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } feeder_state_e;

    function automatic logic [31:0] pack_status(input logic [15:0] level,
                                                input logic        ovf,
                                                input logic [1:0]  st,
                                                input logic        en,
                                                input logic        eor_pending);
        logic [31:0] s;
        s = '0;
        s[ST_LEVEL_LSB +: 16] = level;
        s[ST_OVF_BIT]         = ovf;
        s[ST_STATE_LSB +: 2]  = st;
        s[ST_EN_BIT]          = en;
        s[ST_EOR_BIT]         = eor_pending;
        return s;
    endfunction

endpackage

// File: rtl/caeco_sample_feeder_if.sv
// rtl/caeco_sample_feeder_if.sv - store-path bus and CAECO sample stream bundle
interface caeco_sample_feeder_if #(parameter int DW = 32);
    logic          bus_sel;
    logic          bus_we;
    logic          bus_addr;
    logic [31:0]   bus_wdata;
    logic [31:0]   bus_rdata;
    logic          bus_ready;
    logic          smp_valid;
    logic [DW-1:0] smp_data;
    logic          smp_last;
    logic          smp_ready;

    // master = core/JTAG store path plus the CAECO sink; slave = the feeder
    modport master (
        output bus_sel, bus_we, bus_addr, bus_wdata, smp_ready,
        input  bus_rdata, bus_ready, smp_valid, smp_data, smp_last
    );

    modport slave (
        input  bus_sel, bus_we, bus_addr, bus_wdata, smp_ready,
        output bus_rdata, bus_ready, smp_valid, smp_data, smp_last
    );
endinterface

// File: rtl/caeco_sample_fifo.sv
// rtl/caeco_sample_fifo.sv - synchronous FIFO with flush and in-place tail-flag set
module caeco_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 33
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic                   set_tail_i,
    input  logic [W-1:0]           wdata_i,
    output logic [W-1:0]           rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign level_o = level_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // a pop in the same cycle frees the slot, so a push into a full FIFO is allowed then
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
        if (set_tail_i && !empty_o) mem_q[wr_ptr_q - AW'(1)][W-1] <= 1'b1;
    end
endmodule

// File: rtl/caeco_sample_feeder.sv
// rtl/caeco_sample_feeder.sv - memory-mapped ECG sample feeder into CAECO
// Optional interrupt output enabled by defining CAECO_FEEDER_IRQ_EN.
module caeco_sample_feeder
    import caeco_sample_feeder_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    caeco_sample_feeder_if.slave  io,
    output logic                  caeco_start
`ifdef CAECO_FEEDER_IRQ_EN
    ,
    output logic                  irq
`endif
);
    localparam int AW = $clog2(DEPTH);

    feeder_state_e state_q, state_d;
    logic          bus_ready_q, bus_ready_d;
    logic [31:0]   bus_rdata_q, bus_rdata_d;
    logic          ovf_q, ovf_d;
    logic          en_q, en_d;
    logic          eor_pend_q, eor_pend_d;
    logic          start_q, start_d;

    logic          fifo_push, fifo_pop, fifo_flush, fifo_set_tail;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_level;
    logic [DW:0]   fifo_head;

    logic          first_cycle, commit, stream_on, space_next, empty_next, drain_done;

    caeco_sample_fifo #(.DEPTH(DEPTH), .W(DW + 1)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (fifo_push),
        .pop_i      (fifo_pop),
        .flush_i    (fifo_flush),
        .set_tail_i (fifo_set_tail),
        .wdata_i    ({1'b0, io.bus_wdata[DW-1:0]}),
        .rdata_o    (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .level_o    (fifo_level)
    );

    // an access is decided in its first cycle and takes effect in the ready cycle
    assign first_cycle = io.bus_sel && !bus_ready_q;
    assign commit      = io.bus_sel && bus_ready_q && io.bus_we;

    assign stream_on    = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign io.smp_valid = stream_on && !fifo_empty;
    assign io.smp_data  = io.smp_valid ? fifo_head[DW-1:0] : '0;
    assign io.smp_last  = io.smp_valid && fifo_head[DW];
    assign fifo_pop     = io.smp_valid && io.smp_ready;

    assign space_next = !fifo_full || fifo_pop;
    assign empty_next = fifo_empty || ((fifo_level == (AW+1)'(1)) && fifo_pop);
    assign drain_done = (state_q == S_DRAIN) && fifo_pop && fifo_head[DW];

    assign io.bus_ready = bus_ready_q;
    assign io.bus_rdata = bus_rdata_q;
    assign caeco_start  = start_q;

    always_comb begin
        state_d       = state_q;
        ovf_d         = ovf_q;
        en_d          = en_q;
        eor_pend_d    = eor_pend_q;
        start_d       = 1'b0;
        bus_ready_d   = 1'b0;
        bus_rdata_d   = '0;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        fifo_set_tail = 1'b0;

        if (first_cycle) begin
            if (io.bus_we && io.bus_addr == REG_DATA && state_q == S_RUN)
                bus_ready_d = space_next;
            else
                bus_ready_d = 1'b1;
            if (!io.bus_we && io.bus_addr == REG_CMD)
                bus_rdata_d = pack_status(16'(fifo_level), ovf_q, state_q, en_q, eor_pend_q);
        end

        if (drain_done) begin
            state_d    = S_IDLE;
            eor_pend_d = 1'b0;
        end

        if (commit && io.bus_addr == REG_DATA) begin
            if (state_q == S_RUN) fifo_push = 1'b1;
            else                  ovf_d     = 1'b1;
        end

        if (commit && io.bus_addr == REG_CMD) begin
            en_d = io.bus_wdata[CMD_EN_BIT];
            if (!io.bus_wdata[CMD_EN_BIT]) begin
                fifo_flush = 1'b1;
                ovf_d      = 1'b0;
                eor_pend_d = 1'b0;
                state_d    = S_IDLE;
            end else if (io.bus_wdata[CMD_START_BIT] &&
                         (state_q == S_IDLE || state_q == S_ARMED)) begin
                state_d = S_RUN;
                start_d = 1'b1;
            end else if (io.bus_wdata[CMD_EOR_BIT] && state_q == S_RUN) begin
                // nothing left to mark: the previous sample already went out unflagged
                if (empty_next) begin
                    state_d = S_IDLE;
                end else begin
                    fifo_set_tail = 1'b1;
                    eor_pend_d    = 1'b1;
                    state_d       = S_DRAIN;
                end
            end else if (state_q == S_IDLE) begin
                state_d = S_ARMED;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bus_ready_q <= 1'b0;
            bus_rdata_q <= '0;
            ovf_q       <= 1'b0;
            en_q        <= 1'b0;
            eor_pend_q  <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_ready_q <= bus_ready_d;
            bus_rdata_q <= bus_rdata_d;
            ovf_q       <= ovf_d;
            en_q        <= en_d;
            eor_pend_q  <= eor_pend_d;
            start_q     <= start_d;
        end
    end

`ifdef CAECO_FEEDER_IRQ_EN
    logic irq_q, irq_d, irq_clr;

    assign irq_clr = commit && io.bus_addr == REG_CMD && io.bus_wdata[CMD_IRQ_CLR_BIT];
    assign irq     = irq_q;

    // set beats clear when both land in the same cycle
    always_comb begin
        irq_d = irq_q;
        if (irq_clr)    irq_d = 1'b0;
        if (drain_done) irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end
`endif
endmodule
